// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
// A one-word holding register lets back-to-back words stream with no idle bit.
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             msb_first,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_order;
  logic             hold_full;
  logic             rdy_q;
  logic [WIDTH-1:0] shreg;
  logic             sh_order;
  logic [CW-1:0]    bitcnt;

  logic last_bit;
  logic load;

  assign last_bit = (state == SHIFT) && (bitcnt == LAST);
  // Holding register drains either from idle or on the last bit, so words chain with no gap.
  assign load     = hold_full && ((state == IDLE) || last_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_reg   <= '0;
      hold_order <= 1'b0;
      hold_full  <= 1'b0;
      rdy_q      <= 1'b1;
      shreg      <= '0;
      sh_order   <= 1'b0;
      bitcnt     <= '0;
    end else begin
      // Accept and load are exclusive: rdy_q is low whenever the slot is full.
      if (din_valid && rdy_q) begin
        hold_reg   <= din;
        hold_order <= msb_first;
        hold_full  <= 1'b1;
        rdy_q      <= 1'b0;
      end
      if (load) begin
        shreg     <= hold_reg;
        sh_order  <= hold_order;
        bitcnt    <= '0;
        hold_full <= 1'b0;
        rdy_q     <= 1'b1;
        state     <= SHIFT;
      end else if (state == SHIFT) begin
        if (last_bit) begin
          state  <= IDLE;
          bitcnt <= '0;
        end else begin
          shreg  <= sh_order ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          bitcnt <= bitcnt + 1'b1;
        end
      end
    end
  end

  assign din_ready  = rdy_q;
  assign sout_valid = (state == SHIFT);
  assign sout       = sout_valid ? (sh_order ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;
  assign word_done  = last_bit;
  assign busy       = sout_valid | hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer (WIDTH=8): per-scenario tasks with inline checks.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       msb_first;
  logic       sout;
  logic       sout_valid;
  logic       word_done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  bit_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .msb_first(msb_first), .sout(sout), .sout_valid(sout_valid),
    .word_done(word_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Emission order packed MSB-first: bit 7 of the result is the first bit on sout.
  function automatic logic [7:0] emis(input logic [7:0] w, input logic o);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) e[7-i] = o ? w[7-i] : w[i];
    return e;
  endfunction

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b1; din = '0; din_valid = 1'b0; msb_first = 1'b0;
    #2;
    got = {din_ready, sout_valid, sout, word_done, busy};
    checks++;
    if (got !== 5'b10000) begin
      errors++; $display("FAIL reset_during got=%b exp=10000", got);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got = {din_ready, sout_valid, sout, word_done, busy};
    checks++;
    if (got !== 5'b10000) begin
      errors++; $display("FAIL reset_after got=%b exp=10000", got);
    end
  endtask

  task automatic test_single();
    logic [7:0] pat;
    logic [3:0] got, exp;
    pat = 8'b1101_0000;
    @(negedge clk);
    din = 8'hD0; msb_first = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if ({din_ready, busy, sout_valid} !== 3'b010) begin
      errors++; $display("FAIL single_accept rdy/busy/vld=%b exp=010", {din_ready, busy, sout_valid});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got = {sout_valid, sout, word_done, din_ready};
      exp = {1'b1, pat[7-i], (i == 7), 1'b1};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL single_bit%0d vld/sout/done/rdy=%b exp=%b", i, got, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({sout_valid, sout, busy} !== 3'b000) begin
      errors++; $display("FAIL single_idle vld/sout/busy=%b exp=000", {sout_valid, sout, busy});
    end
  endtask

  task automatic test_lsb();
    logic [7:0] pat;
    logic [2:0] got, exp;
    pat = 8'b1101_0000;
    @(negedge clk);
    din = 8'h0B; msb_first = 1'b0; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got = {sout_valid, sout, word_done};
      exp = {1'b1, pat[7-i], (i == 7)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL lsb_bit%0d vld/sout/done=%b exp=%b", i, got, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({sout_valid, sout} !== 2'b00) begin
      errors++; $display("FAIL lsb_idle vld/sout=%b exp=00", {sout_valid, sout});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    logic [3:0]  got, exp;
    pat = {8'hD0, 8'hAA};
    @(negedge clk);
    din = 8'hD0; msb_first = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({din_ready, sout_valid} !== 2'b00) begin
      errors++; $display("FAIL b2b_first_accept rdy/vld=%b exp=00", {din_ready, sout_valid});
    end
    din = 8'hAA;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      got = {sout_valid, sout, word_done, din_ready};
      exp = {1'b1, pat[15-i], (i == 7 || i == 15), (i == 0 || i >= 8)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b_bit%0d vld/sout/done/rdy=%b exp=%b", i, got, exp);
      end
      if (i == 1) din_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({sout_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL b2b_no_dup vld/busy=%b exp=00", {sout_valid, busy});
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q[$];
    logic       got_q[$];
    logic [7:0] w, g;
    logic       o;
    int sent = 0, cyc = 0, stalls = 0, gaps = 0, nw;
    @(negedge clk);
    w = 8'($urandom); o = 1'($urandom);
    din = w; msb_first = o; din_valid = 1'b1;
    while (sent < 20 && cyc < 1000) begin
      if (sout_valid) got_q.push_back(sout);
      else if (got_q.size() > 0 && busy) gaps++;
      if (din_ready) begin
        exp_q.push_back(emis(w, o));
        sent++;
        @(negedge clk); cyc++;
        if (sent < 20) begin
          w = 8'($urandom); o = 1'($urandom);
          din = w; msb_first = o;
        end else din_valid = 1'b0;
      end else begin
        stalls++;
        @(negedge clk); cyc++;
      end
    end
    din_valid = 1'b0;
    cyc = 0;
    while ((busy || sout_valid) && cyc < 200) begin
      if (sout_valid) got_q.push_back(sout);
      else if (got_q.size() > 0 && busy) gaps++;
      @(negedge clk); cyc++;
    end
    checks++;
    if (sent != 20 || cyc >= 200) begin
      errors++; $display("FAIL bp_timeout sent=%0d drain_cycles=%0d exp sent=20", sent, cyc);
    end
    checks++;
    if (stalls == 0) begin
      errors++; $display("FAIL bp_stall stalls=%0d exp nonzero", stalls);
    end
    checks++;
    if (got_q.size() != 160) begin
      errors++; $display("FAIL bp_bitcount got=%0d exp=160", got_q.size());
    end
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL bp_gaps got=%0d exp=0", gaps);
    end
    nw = got_q.size() / 8;
    if (nw > exp_q.size()) nw = exp_q.size();
    for (int k = 0; k < nw; k++) begin
      for (int i = 0; i < 8; i++) g[7-i] = got_q[8*k+i];
      checks++;
      if (g !== exp_q[k]) begin
        errors++; $display("FAIL bp_word%0d got=%h exp=%h", k, g, exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    int seen = 0;
    @(negedge clk);
    din = 8'hD0; msb_first = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din = 8'h0F;
    @(negedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({din_ready, busy, sout_valid} !== 3'b011) begin
      errors++; $display("FAIL rstmid_held rdy/busy/vld=%b exp=011", {din_ready, busy, sout_valid});
    end
    rst = 1'b1;
    #1;
    got = {din_ready, sout_valid, sout, word_done, busy};
    checks++;
    if (got !== 5'b10000) begin
      errors++; $display("FAIL rstmid_immediate got=%b exp=10000", got);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sout_valid || busy || word_done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rstmid_silent active_cycles=%0d exp=0", seen);
    end
  endtask

  task automatic test_order_change();
    logic [7:0] pat;
    logic [1:0] got, exp;
    pat = 8'b1101_0000;
    @(negedge clk);
    din = 8'hD0; msb_first = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; msb_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      msb_first = ~msb_first;
      got = {sout_valid, sout};
      exp = {1'b1, pat[7-i]};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL order_bit%0d vld/sout=%b exp=%b", i, got, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({sout_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL order_idle vld/busy=%b exp=00", {sout_valid, busy});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lsb();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_order_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the serial pattern-detector FSMs.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on sout, feeding the detector's single-bit input directly.
- A one-word holding register lets consecutive words stream with no idle bit between them.
- Bit order is selectable per word.

Parameters:
- WIDTH, 8: word width in bits. Legal range is WIDTH >= 2.
- IDLE_LEVEL, 1'b0: value driven on sout whenever sout_valid = 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- din  input  WIDTH  parallel word to serialize
- din_valid  input  1  din is presented
- din_ready  output  1  block can accept a word this cycle
- msb_first  input  1  bit order of the word being accepted (1 = MSB first)
- sout  output  1  serial bit to the downstream detector
- sout_valid  output  1  sout carries a data bit this cycle
- word_done  output  1  one-cycle pulse on the last bit of each word
- busy  output  1  a word is being shifted or is held

Behaviour:
- Internal state:
  - hold_reg[WIDTH-1:0], hold_order, hold_full
  - shreg[WIDTH-1:0], sh_order
  - bitcnt [$clog2(WIDTH)-1:0]
  - state in {IDLE, SHIFT}
- Reset (async, any time): state=IDLE, hold_full=0, bitcnt=0, shreg=0, hold_reg=0.
  - Outputs during and after reset: din_ready=1, sout=IDLE_LEVEL, sout_valid=0, word_done=0, busy=0.
  - Reset mid-word discards the partial word and any held word. No further bits of either appear.
- Handshake:
  - din_ready = ~hold_full, driven directly from a register.
  - A transfer occurs on a rising edge where din_valid & din_ready. At that edge hold_reg<=din, hold_order<=msb_first, hold_full<=1.
  - din and msb_first are don't-care when no transfer occurs.
- IDLE:
  - sout_valid=0, sout=IDLE_LEVEL.
  - If hold_full: at the next edge shreg<=hold_reg, sh_order<=hold_order, bitcnt<=0, hold_full<=0, state<=SHIFT.
- SHIFT:
  - sout_valid=1.
  - sout = sh_order ? shreg[WIDTH-1] : shreg[0].
  - Each edge shifts shreg toward the emitting end (left if sh_order, else right) and increments bitcnt.
- Last bit (bitcnt==WIDTH-1):
  - word_done=1 for that cycle.
  - At the edge: if hold_full, reload shreg/sh_order from the holding register, set bitcnt=0, clear hold_full and stay in SHIFT. There is no gap bit.
  - Otherwise state<=IDLE.
- Latency:
  - Word accepted at edge E is loaded at edge E+1 when the block was idle. Its first bit is on sout in the cycle after E+1.
  - It takes exactly WIDTH cycles to emit.
- Simultaneous events:
  - Accept and load never coincide on the same hold slot, because din_ready=0 while hold_full.
  - When a load frees the slot at edge E, din_ready=1 from E onward.
  - A word accepted in the last-bit cycle (hold empty before that edge) produces exactly one idle cycle (sout_valid=0) before its first bit. Continuous streaming requires the next word to be accepted by the last-bit cycle, which allows WIDTH-1 cycles of slack.
- msb_first is captured per word. Changing it mid-word has no effect on bits in flight.
- busy = (state==SHIFT) | hold_full.
- All outputs are functions of registers only. There is no combinational path from din/din_valid to any output.

Test Plan:
- Single word: reset, then din=8'hD0, msb_first=1, one-cycle valid → sout_valid high for 8 cycles starting 2 cycles after the accept edge. sout=1,1,0,1,0,0,0,0. word_done high on the 8th bit. Detector output asserts after the 4th bit.
- LSB order: din=8'h0B, msb_first=0 → sout=1,1,0,1,0,0,0,0. After that, sout_valid=0 and sout=IDLE_LEVEL.
- Back-to-back: din_valid held high with 8'hD0 then 8'hAA → 16 consecutive valid bits with no gap. din_ready drops the cycle after each accept and rises the cycle after each load. Each word is accepted exactly once.
- Backpressure: third word presented while hold_full=1 → din_ready=0. The word is accepted only after the next load. No word is lost or duplicated across 20 random words (scoreboard compare).
- Reset mid-word: assert rst during bit 3 with a word held → outputs go to reset values immediately. After rst deasserts, nothing is emitted until a new accept.
- Order change mid-word: msb_first toggled while shifting 8'hD0 (msb_first=1) → emitted bits are unchanged.
